// File: rtl/rd_merge_pkg.sv
// Shared types for the read-channel packet merger: FSM states, channel
// count and the round-robin pick helper used by the arbiter.
package rd_merge_pkg;

  localparam int NUM_CHAN = 4;
  localparam int CHAN_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } merge_state_e;

  typedef struct packed {
    logic              found;
    logic [CHAN_W-1:0] idx;
  } rr_pick_t;

  // Search last+1, last+2, last+3, last (mod NUM_CHAN); first requester wins.
  function automatic rr_pick_t rr_pick(input logic [NUM_CHAN-1:0] req,
                                       input logic [CHAN_W-1:0]   last);
    rr_pick_t          pick;
    logic [CHAN_W-1:0] cand;
    pick = '0;
    for (int i = 1; i <= NUM_CHAN; i++) begin
      cand = last + CHAN_W'(i);
      if (!pick.found && req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/merge_out_buf.sv
// Output buffer of the merger: BUF_DEPTH entries total, one of which is the
// registered head presented to the sink; the rest sit in a small RAM.
module merge_out_buf
  import rd_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int BUF_AW     = 2,
  parameter int EW         = CHAN_W + 2 + DATA_WIDTH
) (
  input  logic          rd_clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [EW-1:0] out_data,
  output logic [BUF_AW:0] count
);

  logic [EW-1:0]     mem [BUF_DEPTH];
  logic [BUF_AW-1:0] wr_ptr;
  logic [BUF_AW-1:0] rd_ptr;
  logic [BUF_AW:0]   mem_cnt;
  logic              pop;
  logic              load_head;
  logic              from_mem;
  logic              to_mem;

  assign pop       = out_valid & out_ready;
  // The head register refills whenever it is empty or being consumed.
  assign load_head = !out_valid || pop;
  assign from_mem  = load_head && (mem_cnt != '0);
  // A push bypasses the RAM only when the head refills and the RAM is empty.
  assign to_mem    = push && !(load_head && (mem_cnt == '0));
  assign count     = mem_cnt + (BUF_AW+1)'(out_valid);

  // Head register, pointers and RAM occupancy.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (load_head) begin
        if (mem_cnt != '0) begin
          out_data  <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (push) begin
          out_data  <= push_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (from_mem) rd_ptr <= rd_ptr + 1'b1;
      if (to_mem)   wr_ptr <= wr_ptr + 1'b1;
      mem_cnt <= mem_cnt + (BUF_AW+1)'(to_mem) - (BUF_AW+1)'(from_mem);
    end
  end

  // RAM write port.
  always_ff @(posedge rd_clk) begin
    // NOTE: the RAM itself is not reset; pointers and counts decide which
    // entries are meaningful, so clearing it would only cost reset fan-out.
    if (to_mem) mem[wr_ptr] <= push_data;
  end

  overflow_a: assert property (@(posedge rd_clk) disable iff (!rst_n)
    !(push && !pop && (count == (BUF_AW+1)'(BUF_DEPTH))));

endmodule

// File: rtl/rd_chan_pkt_merger.sv
// Round-robin merger of four read-channel FIFOs into one tagged
// valid/ready stream. A granted channel is drained for PKT_LEN words,
// throttled only by the credit left in the output buffer.
module rd_chan_pkt_merger
  import rd_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 16,
  parameter int BUF_DEPTH  = 4,
  parameter int BUF_AW     = 2
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic [NUM_CHAN-1:0]   chan_en,
  input  logic                  rd_valid0,
  input  logic                  rd_valid1,
  input  logic                  rd_valid2,
  input  logic                  rd_valid3,
  input  logic [DATA_WIDTH-1:0] rd_data0,
  input  logic [DATA_WIDTH-1:0] rd_data1,
  input  logic [DATA_WIDTH-1:0] rd_data2,
  input  logic [DATA_WIDTH-1:0] rd_data3,
  output logic                  rd_en0,
  output logic                  rd_en1,
  output logic                  rd_en2,
  output logic                  rd_en3,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CHAN_W-1:0]     m_chan,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  pkt_done
);

  localparam int          EW       = CHAN_W + 2 + DATA_WIDTH;
  localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);

  logic [NUM_CHAN-1:0]   valid_vec;
  logic [DATA_WIDTH-1:0] data_vec [NUM_CHAN];
  logic [NUM_CHAN-1:0]   rd_en_vec;
  merge_state_e          state;
  merge_state_e          state_nxt;
  rr_pick_t              pick;
  logic [CHAN_W-1:0]     grant;
  logic [CHAN_W-1:0]     last;
  logic [7:0]            word_cnt;
  logic                  issue;
  logic                  inflight;
  logic [CHAN_W-1:0]     ch_d;
  logic                  sop_d;
  logic                  eop_d;
  logic [BUF_AW:0]       occupancy;
  logic [BUF_AW+1:0]     used;
  logic                  has_credit;
  logic [EW-1:0]         push_data;
  logic [EW-1:0]         head;

  assign valid_vec = {rd_valid3, rd_valid2, rd_valid1, rd_valid0};
  assign data_vec  = '{rd_data0, rd_data1, rd_data2, rd_data3};
  assign {rd_en3, rd_en2, rd_en1, rd_en0} = rd_en_vec;

  assign pick = rr_pick(valid_vec & chan_en, last);

  // Credit uses registered terms only, so m_ready never reaches rd_en.
  assign used       = {1'b0, occupancy} + (BUF_AW+2)'(inflight);
  assign has_credit = used < (BUF_AW+2)'(BUF_DEPTH);

  // Next-state and read-request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    rd_en_vec = '0;
    issue     = 1'b0;
    pkt_done  = 1'b0;
    case (state)
      IDLE: if (pick.found) state_nxt = READ;
      READ: begin
        issue            = has_credit;
        rd_en_vec[grant] = has_credit;
        if (has_credit && (word_cnt == LAST_IDX)) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, grant/round-robin pointer and per-packet word counter.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= CHAN_W'(NUM_CHAN - 1);
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && pick.found) begin
        grant    <= pick.idx;
        last     <= pick.idx;
        word_cnt <= '0;
      end else if (issue) begin
        word_cnt <= word_cnt + 8'd1;
      end
    end
  end

  // Read pipeline: tags travel alongside the one-cycle FIFO read latency.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      ch_d     <= '0;
      sop_d    <= 1'b0;
      eop_d    <= 1'b0;
    end else begin
      inflight <= issue;
      ch_d     <= grant;
      sop_d    <= (word_cnt == 8'd0);
      eop_d    <= (word_cnt == LAST_IDX);
    end
  end

  assign push_data = {ch_d, sop_d, eop_d, data_vec[ch_d]};

  merge_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .BUF_AW     (BUF_AW)
  ) u_buf (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (push_data),
    .out_ready (m_ready),
    .out_valid (m_valid),
    .out_data  (head),
    .count     (occupancy)
  );

  assign {m_chan, m_sop, m_eop, m_data} = head;

endmodule

// File: tb/tb_rd_chan_pkt_merger.sv
// Directed bench for rd_chan_pkt_merger: channel FIFO models that return
// (chan<<16 | seq), a stream scoreboard and per-phase expected counts.
module tb_rd_chan_pkt_merger;

  localparam int DW = 32;
  localparam int PL = 16;
  localparam int BD = 4;

  logic          rd_clk  = 1'b0;
  logic          rst_n   = 1'b0;
  logic [3:0]    chan_en = 4'h0;
  logic [3:0]    rv      = 4'h0;
  logic [DW-1:0] rdd [4];
  logic          rd_en0, rd_en1, rd_en2, rd_en3;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    m_chan;
  logic          m_sop, m_eop, pkt_done;
  logic [3:0]    ren;

  assign ren = {rd_en3, rd_en2, rd_en1, rd_en0};

  always #5 rd_clk = ~rd_clk;

  rd_chan_pkt_merger #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PL),
    .BUF_DEPTH  (BD),
    .BUF_AW     (2)
  ) dut (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .chan_en   (chan_en),
    .rd_valid0 (rv[0]),
    .rd_valid1 (rv[1]),
    .rd_valid2 (rv[2]),
    .rd_valid3 (rv[3]),
    .rd_data0  (rdd[0]),
    .rd_data1  (rdd[1]),
    .rd_data2  (rdd[2]),
    .rd_data3  (rdd[3]),
    .rd_en0    (rd_en0),
    .rd_en1    (rd_en1),
    .rd_en2    (rd_en2),
    .rd_en3    (rd_en3),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_chan    (m_chan),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .pkt_done  (pkt_done)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Channel FIFO models: read data appears the cycle after rd_en.
  int fseq [4];
  always @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        rdd[c]  <= '0;
        fseq[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (ren[c]) begin
          rdd[c]  <= (32'(c) << 16) | 32'(fseq[c]);
          fseq[c] <= fseq[c] + 1;
        end
      end
    end
  end

  int tb_cyc = 0;
  always @(posedge rd_clk) tb_cyc++;

  // Monitor / scoreboard, cleared by every reset.
  int   en_cnt [4];
  int   en_first [4];
  int   en_last [4];
  int   exp_seq [4];
  int   done_cnt, pops, valid_cnt, multi_en, credit_viol, stab_viol;
  int   max_occ, max_dcnt, occ, first_valid, m_nen, m_credit;
  bit   inflight, stalled;
  logic [DW+3:0] prev_out;
  int   sop_q [$];
  int   sop_cyc [$];
  int   eop_cyc [$];

  always @(negedge rd_clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        en_cnt[c] = 0; en_first[c] = -1; en_last[c] = -1; exp_seq[c] = 0;
      end
      done_cnt = 0; pops = 0; valid_cnt = 0; multi_en = 0; credit_viol = 0;
      stab_viol = 0; max_occ = 0; max_dcnt = 0; occ = 0; first_valid = -1;
      inflight = 0; stalled = 0; prev_out = '0;
      sop_q.delete(); sop_cyc.delete(); eop_cyc.delete();
    end else begin
      m_nen = $countones(ren);
      if (m_nen > 1) multi_en++;
      for (int c = 0; c < 4; c++) begin
        if (ren[c]) begin
          en_cnt[c]++;
          if (en_first[c] < 0) en_first[c] = tb_cyc;
          en_last[c] = tb_cyc;
        end
      end
      if (pkt_done) done_cnt++;
      m_credit = BD - occ - int'(inflight);
      if (m_nen != 0 && m_credit <= 0) credit_viol++;
      if (stalled && (!m_valid || {m_chan, m_sop, m_eop, m_data} !== prev_out)) stab_viol++;
      if (int'(dut.u_buf.count) > max_dcnt) max_dcnt = int'(dut.u_buf.count);
      if (m_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = tb_cyc;
      end
      if (m_valid && m_ready) begin
        check("sb_data", m_data, (32'(m_chan) << 16) | 32'(exp_seq[m_chan]));
        check("sb_sop", 32'(m_sop), 32'((exp_seq[m_chan] % PL) == 0));
        check("sb_eop", 32'(m_eop), 32'((exp_seq[m_chan] % PL) == PL - 1));
        if (m_sop) begin
          sop_q.push_back(int'(m_chan));
          sop_cyc.push_back(tb_cyc);
        end
        if (m_eop) eop_cyc.push_back(tb_cyc);
        exp_seq[m_chan]++;
        pops++;
      end
      occ      = occ + int'(inflight) - int'(m_valid && m_ready);
      if (occ > max_occ) max_occ = occ;
      inflight = (m_nen != 0);
      stalled  = m_valid && !m_ready;
      prev_out = {m_chan, m_sop, m_eop, m_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    tick(1);
    rst_n = 1'b0;
    rv    = 4'h0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic common_checks(input string tag);
    check({tag, "_one_rd_en"}, 32'(multi_en), 0);
    check({tag, "_stable"}, 32'(stab_viol), 0);
    check({tag, "_credit"}, 32'(credit_viol), 0);
    check({tag, "_occ_le4"}, 32'(max_occ <= BD), 1);
    check({tag, "_bufcnt_le4"}, 32'(max_dcnt <= BD), 1);
    check({tag, "_pops_eq_reads"}, 32'(pops), 32'(en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3]));
  endtask

  int grant_cyc, k, snap, exp1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Phase 1: reset values, then idle with no requests.
    repeat (3) @(negedge rd_clk);
    check("rst_rd_en", 32'(ren), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_chan", 32'(m_chan), 0);
    check("rst_sop_eop", 32'({m_sop, m_eop}), 0);
    check("rst_pkt_done", 32'(pkt_done), 0);
    tick(1);
    rst_n   = 1'b1;
    chan_en = 4'hF;
    m_ready = 1'b1;
    tick(100);
    check("idle_rd_en", 32'(en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3]), 0);
    check("idle_m_valid", 32'(valid_cnt), 0);

    // Phase 2: single packet from channel 2.
    rv[2]     = 1'b1;
    grant_cyc = tb_cyc;
    tick(1);
    rv[2]     = 1'b0;
    tick(30);
    check("p2_latency", 32'(first_valid - grant_cyc), 3);
    check("p2_rd_en2", 32'(en_cnt[2]), 16);
    check("p2_back2back", 32'(en_last[2] - en_first[2]), 15);
    check("p2_other_en", 32'(en_cnt[0] + en_cnt[1] + en_cnt[3]), 0);
    check("p2_pkt_done", 32'(done_cnt), 1);
    check("p2_sop_cnt", 32'(sop_q.size()), 1);
    if (sop_q.size() == 1) check("p2_sop_chan", 32'(sop_q[0]), 2);
    check("p2_eop_cnt", 32'(eop_cyc.size()), 1);
    check("p2_seq2", 32'(exp_seq[2]), 16);
    common_checks("p2");

    // Phase 3: all channels requesting, round-robin from channel 0.
    do_reset();
    rv = 4'hF;
    tick(80);
    rv = 4'h0;
    tick(30);
    check("p3_pkts", 32'(sop_q.size()), 5);
    check("p3_pkt_done", 32'(done_cnt), 5);
    for (int i = 0; i < 5 && i < sop_q.size(); i++)
      check($sformatf("p3_order%0d", i), 32'(sop_q[i]), 32'(i % 4));
    for (int i = 0; i < 4 && i + 1 < sop_cyc.size() && i < eop_cyc.size(); i++)
      check($sformatf("p3_gap%0d", i), 32'(sop_cyc[i + 1] - eop_cyc[i]), 2);
    check("p3_en0", 32'(en_cnt[0]), 32);
    check("p3_en3", 32'(en_cnt[3]), 16);
    common_checks("p3");

    // Phase 4: channel 1 traffic with a randomly stalling sink.
    do_reset();
    rv[1] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    rv[1] = 1'b0;
    for (int i = 0; i < 120; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    m_ready = 1'b1;
    tick(20);
    check("p4_some_pkts", 32'(en_cnt[1] >= PL), 1);
    check("p4_whole_pkts", 32'(en_cnt[1] % PL), 0);
    check("p4_all_words", 32'(exp_seq[1]), 32'(en_cnt[1]));
    check("p4_done", 32'(done_cnt * PL), 32'(en_cnt[1]));
    common_checks("p4");

    // Phase 5: channel 3 masked; channel 1 masked mid-packet.
    do_reset();
    chan_en = 4'b0111;
    rv      = 4'hF;
    k = 0;
    while (ren[1] && k < 200) begin tick(1); k++; end
    while (!ren[1] && k < 200) begin tick(1); k++; end
    check("p5_find_ch1", 32'(k < 200), 1);
    tick(4);
    chan_en = 4'b0101;
    snap    = en_cnt[1];
    exp1    = ((snap + PL - 1) / PL) * PL;
    tick(80);
    rv = 4'h0;
    tick(40);
    check("p5_mid_pkt", 32'(snap % PL), 4);
    check("p5_ch3_never", 32'(en_cnt[3]), 0);
    check("p5_ch1_reads", 32'(en_cnt[1]), 32'(exp1));
    check("p5_ch1_words", 32'(exp_seq[1]), 32'(exp1));
    check("p5_ch0_served", 32'(en_cnt[0] > 0), 1);
    common_checks("p5");
    chan_en = 4'hF;

    // Phase 6: reset in the middle of a channel 0 packet.
    do_reset();
    rv[0] = 1'b1;
    k = 0;
    while (k < 8) begin
      @(negedge rd_clk);
      if (ren[0]) k++;
      if (tb_cyc > 20000) break;
    end
    check("p6_reach_word7", 32'(k), 8);
    rst_n = 1'b0;
    #1;
    check("p6_rst_rd_en", 32'(ren), 0);
    check("p6_rst_m_valid", 32'(m_valid), 0);
    check("p6_rst_m_data", m_data, 0);
    check("p6_rst_m_chan", 32'(m_chan), 0);
    check("p6_rst_sop_eop", 32'({m_sop, m_eop}), 0);
    check("p6_rst_pkt_done", 32'(pkt_done), 0);
    tick(2);
    rv    = 4'b0011;
    rst_n = 1'b1;
    tick(20);
    rv = 4'h0;
    tick(30);
    check("p6_pkts", 32'(sop_q.size()), 2);
    if (sop_q.size() == 2) begin
      check("p6_first_ch0", 32'(sop_q[0]), 0);
      check("p6_then_ch1", 32'(sop_q[1]), 1);
    end
    check("p6_ch0_words", 32'(exp_seq[0]), 16);
    common_checks("p6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rd_chan_pkt_merger.md
Name: rd_chan_pkt_merger

Overview:
- Downstream consumer of the four read-channel FIFO user ports of the multi-channel DDR3 read interface, in the rd_clk domain.
- Arbitrates round-robin among channels that hold a full packet and reads PKT_LEN words back-to-back from the granted channel.
- Emits one merged valid/ready stream tagged with channel ID and start-of-packet/end-of-packet markers, for a single downstream sink (display/UART/Ethernet packer).

Parameters:
- DATA_WIDTH, 32, width of rd_data0..3 and m_data; equals FIFO_RD_WIDTH.
- PKT_LEN, 16, words per packet; range 1..256.
- BUF_DEPTH, 4, output buffer entries; power of two, ≥4.
- BUF_AW, 2, log2(BUF_DEPTH).

Ports:
- rd_clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- chan_en  in  4  per-channel arbitration enable.
- rd_valid0..3  in  1 each  channel FIFO holds ≥PKT_LEN words.
- rd_data0..3  in  DATA_WIDTH each  channel FIFO read data; valid 1 cycle after rd_en.
- rd_en0..3  out  1 each  channel FIFO read request.
- m_valid  out  1  output word valid.
- m_ready  in  1  sink accepts word.
- m_data  out  DATA_WIDTH  output word.
- m_chan  out  2  source channel of m_data.
- m_sop  out  1  first word of packet.
- m_eop  out  1  last word of packet.
- pkt_done  out  1  1-cycle pulse per packet fully read from the channel FIFO.

Behaviour:
- Reset is asynchronous, active-low (rst_n), clock rd_clk. Reset clears all state. Values during reset: rd_en*=0, m_valid=0, m_data=0, m_chan=0, m_sop=0, m_eop=0, pkt_done=0, round-robin pointer last=3 (so ch0 has first priority), buffer empty.
- Channel FIFO contract: rd_valid asserted only when count ≥ PKT_LEN. Once a channel is granted, its PKT_LEN reads are issued without rechecking rd_valid.
- FSM states:
  - IDLE: request = rd_valid & chan_en. Search order last+1, last+2, last+3, last (mod 4). If any request is set, register grant, set last=grant, go to READ. Else stay in IDLE.
  - READ: assert rd_en[grant] while credit>0, where credit = BUF_DEPTH − occupancy − inflight (registered terms only; no combinational path from m_ready to rd_en). word_cnt increments per issued rd_en. On issue of word PKT_LEN−1: pulse pkt_done the same cycle, go to IDLE.
- At most one rd_en* is high per cycle, and only in READ.
- Read pipeline: rd_en in cycle N. rd_data[ch_d] is written into the buffer at the end of N+1, with ch_d = grant registered with rd_en. sop = (word index 0) and eop = (word index PKT_LEN−1) are tagged at write time. The word is presented on m_* in cycle N+2.
- Minimum latency, IDLE grant cycle T to first m_valid: T+3.
- Sustained throughput with m_ready=1: 1 word/cycle within a packet. There is 1 idle arbitration cycle between packets.
- Output handshake: m_data, m_chan, m_sop and m_eop stay stable while m_valid=1 and m_ready=0. A pop occurs on m_valid & m_ready. A push and a pop in the same cycle are both honoured.
- Buffer full: credit=0 stalls rd_en. The buffer never overflows; overflow is a verification assertion.
- Buffer empty: m_valid=0.
- chan_en dropped mid-packet: the packet completes; the change affects only the next arbitration.
- PKT_LEN=1: sop=eop=1 on every word.
- word_cnt width is 8 bits; it wraps only through the return to IDLE.

Decomposition:
- Shared package rd_merge_pkg: FSM state encoding (IDLE, READ), NUM_CHAN=4, CHAN_W=2.
- One sub-module: merge_out_buf, a synchronous BUF_DEPTH-entry FIFO of {chan, sop, eop, data} with registered outputs and a count output.
- Arbiter and FSM live in the top module.

Test Plan:
- Reset release, all rd_valid=0 → rd_en*=0 and m_valid=0 for 100 cycles; the FSM stays in IDLE.
- Only rd_valid2=1, chan_en=4'hF, m_ready=1, PKT_LEN=16, rd_data2 = incrementing counter → 16 consecutive rd_en2 pulses. Words appear in order with m_chan=2, sop on word 0, eop on word 15, one pkt_done pulse. First m_valid 3 cycles after grant.
- All four rd_valid=1 held → grant order 0,1,2,3,0,…. Each packet is 16 words, separated by exactly 1 idle cycle at m_ready=1.
- m_ready toggled randomly (50%) during ch1 traffic → no words dropped or duplicated, m_* stable while stalled, buffer count ≤4, rd_en1 deasserts whenever credit=0.
- chan_en=4'b0111 with all rd_valid=1 → channel 3 is never granted. Clearing chan_en[1] mid-packet on ch1 → that packet completes with all 16 words and eop; ch1 is not granted afterwards.
- rst_n asserted mid-packet on ch0 (word 7) → all outputs clear immediately. After release, ch0 is granted first and a fresh 16-word packet starts with sop.
